// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//   Upstream control stage for alu_with_reg. It accepts packed instruction
//   words over a valid/ready handshake and drives one registered ALU step per
//   clock. ALU results (alu_out/alu_cout) are captured into a result register
//   whenever the sequencer runs an EXEC or REPEAT step.
//
//   Instruction word: {op[1:0], addr[1:0], data[BIT_WIDTH-1:0]}
//     00 LDI    : one cycle, write data into ALU register addr
//     01 EXEC   : one cycle, run op s=data[0] on register addr, capture result
//     10 WAIT   : idle the ALU for data+1 cycles
//     11 REPEAT : EXEC for data[BIT_WIDTH-1:1]+1 consecutive cycles
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   instr_valid     instr holds a valid word
//   instr_ready     sequencer is idle and will accept a word this cycle
//   instr           packed instruction word (BIT_WIDTH+4 bits)
//   alu_in          data to alu_with_reg.in
//   alu_reg_addr    register address to alu_with_reg.reg_addr
//   alu_s_reg       register write strobe to alu_with_reg.s_reg
//   alu_s           operation select to alu_with_reg.s
//   alu_out         result from alu_with_reg.out
//   alu_cout        carry from alu_with_reg.cout
//   result          last captured alu_out
//   result_cout     last captured alu_cout
//   result_valid    one-cycle pulse following every capture edge
//   busy            sequencer is not idle
//   exec_count      (ALU_SEQ_EXEC_CNT_EN only) wrapping count of capture edges
//
// Configuration
//   ALU_SEQ_EXEC_CNT_EN : when defined, adds the 16-bit exec_count output.
// -----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int BIT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [BIT_WIDTH+3:0]   instr,
  output logic [BIT_WIDTH-1:0]   alu_in,
  output logic [1:0]             alu_reg_addr,
  output logic                   alu_s_reg,
  output logic                   alu_s,
  input  logic [BIT_WIDTH-1:0]   alu_out,
  input  logic                   alu_cout,
  output logic [BIT_WIDTH-1:0]   result,
  output logic                   result_cout,
  output logic                   result_valid,
`ifdef ALU_SEQ_EXEC_CNT_EN
  output logic [15:0]            exec_count,
`endif
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_REPEAT = 2'd3
  } state_t;

  localparam logic [1:0] OP_LDI    = 2'b00;
  localparam logic [1:0] OP_EXEC   = 2'b01;
  localparam logic [1:0] OP_WAIT   = 2'b10;
  localparam logic [1:0] OP_REPEAT = 2'b11;

  // Decrement that holds at zero so the cycle counter can never wrap.
  function automatic logic [BIT_WIDTH-1:0] sat_dec(input logic [BIT_WIDTH-1:0] v);
    if (v == '0) return '0;
    else         return v - 1'b1;
  endfunction

  state_t                 state, state_nxt;
  logic [BIT_WIDTH-1:0]   cnt, cnt_nxt;
  // Set when the single ISSUE cycle belongs to an EXEC (capture at its end).
  logic                   issue_cap, issue_cap_nxt;

  logic [BIT_WIDTH-1:0]   alu_in_nxt;
  logic [1:0]             alu_reg_addr_nxt;
  logic                   alu_s_reg_nxt;
  logic                   alu_s_nxt;

  logic [1:0]             op;
  logic [1:0]             addr;
  logic [BIT_WIDTH-1:0]   data;
  logic                   accept;
  logic                   cap;

  assign op   = instr[BIT_WIDTH+3:BIT_WIDTH+2];
  assign addr = instr[BIT_WIDTH+1:BIT_WIDTH];
  assign data = instr[BIT_WIDTH-1:0];

  assign instr_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign accept      = instr_valid && instr_ready;

  // A capture edge ends every EXEC issue cycle and every REPEAT cycle.
  assign cap = ((state == S_ISSUE) && issue_cap) || (state == S_REPEAT);

  // Next-state and next-output logic; ALU controls are registered so they
  // are stable for the whole step they describe.
  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    issue_cap_nxt    = issue_cap;
    alu_in_nxt       = '0;
    alu_reg_addr_nxt = 2'b00;
    alu_s_reg_nxt    = 1'b0;
    alu_s_nxt        = 1'b0;

    case (state)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_LDI: begin
              state_nxt        = S_ISSUE;
              issue_cap_nxt    = 1'b0;
              alu_in_nxt       = data;
              alu_reg_addr_nxt = addr;
              alu_s_reg_nxt    = 1'b1;
            end
            OP_EXEC: begin
              state_nxt        = S_ISSUE;
              issue_cap_nxt    = 1'b1;
              alu_reg_addr_nxt = addr;
              alu_s_nxt        = data[0];
            end
            OP_WAIT: begin
              state_nxt = S_WAIT;
              cnt_nxt   = data;
            end
            default: begin
              state_nxt        = S_REPEAT;
              cnt_nxt          = {1'b0, data[BIT_WIDTH-1:1]};
              alu_reg_addr_nxt = addr;
              alu_s_nxt        = data[0];
            end
          endcase
        end
      end
      S_ISSUE: begin
        state_nxt     = S_IDLE;
        issue_cap_nxt = 1'b0;
      end
      S_WAIT: begin
        if (cnt == '0) state_nxt = S_IDLE;
        else           cnt_nxt   = sat_dec(cnt);
      end
      S_REPEAT: begin
        if (cnt == '0) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt          = sat_dec(cnt);
          alu_reg_addr_nxt = alu_reg_addr;
          alu_s_nxt        = alu_s;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- p0: control state and registered ALU drive ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      issue_cap    <= 1'b0;
      alu_in       <= '0;
      alu_reg_addr <= 2'b00;
      alu_s_reg    <= 1'b0;
      alu_s        <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      issue_cap    <= issue_cap_nxt;
      alu_in       <= alu_in_nxt;
      alu_reg_addr <= alu_reg_addr_nxt;
      alu_s_reg    <= alu_s_reg_nxt;
      alu_s        <= alu_s_nxt;
    end
  end

  // ---- p1: result capture ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result       <= '0;
      result_cout  <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= cap;
      if (cap) begin
        result      <= alu_out;
        result_cout <= alu_cout;
      end
    end
  end

`ifdef ALU_SEQ_EXEC_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      exec_count <= 16'd0;
    else if (cap) exec_count <= exec_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         instr_valid;
  logic         instr_ready;
  logic [W+3:0] instr;
  logic [W-1:0] alu_in;
  logic [1:0]   alu_reg_addr;
  logic         alu_s_reg;
  logic         alu_s;
  logic [W-1:0] alu_out;
  logic         alu_cout;
  logic [W-1:0] result;
  logic         result_cout;
  logic         result_valid;
  logic         busy;
`ifdef ALU_SEQ_EXEC_CNT_EN
  logic [15:0]  exec_count;
  logic [15:0]  ec_before;
`endif

  int checks = 0;
  int errors = 0;

  alu_sequencer #(.BIT_WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .alu_in       (alu_in),
    .alu_reg_addr (alu_reg_addr),
    .alu_s_reg    (alu_s_reg),
    .alu_s        (alu_s),
    .alu_out      (alu_out),
    .alu_cout     (alu_cout),
    .result       (result),
    .result_cout  (result_cout),
    .result_valid (result_valid),
`ifdef ALU_SEQ_EXEC_CNT_EN
    .exec_count   (exec_count),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int  n;
  int  rv_cnt;
  logic bad_sreg;
  logic bad_in;

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    alu_out     = '0;
    alu_cout    = 1'b0;
    #12;
    // Reset state
    check("rst_ready",  instr_ready, 1);
    check("rst_busy",   busy, 0);
    check("rst_sreg",   alu_s_reg, 0);
    check("rst_in",     alu_in, 0);
    check("rst_result", result, 0);
    check("rst_rv",     result_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Back-to-back LDI with valid held high
    instr_valid = 1'b1;
    instr = {2'b00, 2'b00, 4'b0100};
    step();
    check("ldi0_sreg",  alu_s_reg, 1);
    check("ldi0_in",    alu_in, 4);
    check("ldi0_addr",  alu_reg_addr, 0);
    check("ldi0_ready", instr_ready, 0);
    instr = {2'b00, 2'b01, 4'b0011};
    step();
    check("ldi0_sreg_off", alu_s_reg, 0);
    check("ldi0_idle",     instr_ready, 1);
    step();
    check("ldi1_sreg", alu_s_reg, 1);
    check("ldi1_in",   alu_in, 3);
    check("ldi1_addr", alu_reg_addr, 1);
    instr_valid = 1'b0;
    step();
    check("ldi1_sreg_off", alu_s_reg, 0);
    check("ldi1_busy",     busy, 0);
    check("ldi_no_rv",     result_valid, 0);

    // EXEC addr 1, s=1
    alu_out = 4'b0111;
    alu_cout = 1'b0;
    instr_valid = 1'b1;
    instr = {2'b01, 2'b01, 4'b0001};
    step();
    instr_valid = 1'b0;
    check("exec_s",    alu_s, 1);
    check("exec_addr", alu_reg_addr, 1);
    check("exec_sreg", alu_s_reg, 0);
    check("exec_busy", busy, 1);
    check("exec_rv0",  result_valid, 0);
    step();
    check("exec_result", result, 4'b0111);
    check("exec_cout",   result_cout, 0);
    check("exec_rv",     result_valid, 1);
    check("exec_idle",   busy, 0);
    alu_out = 4'b1111;
    step();
    check("exec_rv_off", result_valid, 0);
    check("exec_hold",   result, 4'b0111);

    // WAIT data=0 -> exactly one busy cycle
    instr_valid = 1'b1;
    instr = {2'b10, 2'b00, 4'h0};
    step();
    instr_valid = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
    check("wait0_cycles", n, 1);

    // WAIT data=F -> 16 busy cycles; instr_valid toggled with an LDI word
    instr_valid = 1'b1;
    instr = {2'b10, 2'b00, 4'hF};
    step();
    instr = {2'b00, 2'b10, 4'h5};
    n = 0;
    bad_sreg = 1'b0;
    bad_in = 1'b0;
    while (busy && n < 40) begin
      if (alu_s_reg) bad_sreg = 1'b1;
      if (alu_in != 0) bad_in = 1'b1;
      n++;
      instr_valid = n[0];
      step();
    end
    instr_valid = 1'b0;
    check("waitF_cycles", n, 16);
    check("waitF_sreg",   bad_sreg, 0);
    check("waitF_in",     bad_in, 0);
    check("waitF_result", result, 4'b0111);
    step();
    check("waitF_no_accept", busy, 0);

    // REPEAT data=0111 -> n=4, s=1
`ifdef ALU_SEQ_EXEC_CNT_EN
    ec_before = exec_count;
    check("exec_count_exec", exec_count, 1);
`endif
    alu_out = 4'b1010;
    alu_cout = 1'b1;
    instr_valid = 1'b1;
    instr = {2'b11, 2'b10, 4'b0111};
    step();
    instr_valid = 1'b0;
    check("rep4_s",    alu_s, 1);
    check("rep4_addr", alu_reg_addr, 2);
    check("rep4_rv0",  result_valid, 0);
    rv_cnt = 0;
    n = 0;
    while (n < 20) begin
      n++;
      step();
      if (result_valid) rv_cnt++;
      else if (rv_cnt > 0) break;
    end
    check("rep4_rv_cycles", rv_cnt, 4);
    check("rep4_result",    result, 4'b1010);
    check("rep4_cout",      result_cout, 1);
    check("rep4_idle",      busy, 0);
`ifdef ALU_SEQ_EXEC_CNT_EN
    check("rep4_exec_count", exec_count - ec_before, 4);
`endif

    // REPEAT count field 0 -> one capture
    alu_out = 4'b0101;
    alu_cout = 1'b0;
    instr_valid = 1'b1;
    instr = {2'b11, 2'b00, 4'b0000};
    step();
    instr_valid = 1'b0;
    rv_cnt = 0;
    n = 0;
    while (n < 20) begin
      n++;
      step();
      if (result_valid) rv_cnt++;
      else if (rv_cnt > 0) break;
    end
    check("rep1_rv_cycles", rv_cnt, 1);
    check("rep1_result",    result, 4'b0101);

    // Reset mid-REPEAT (count field 7)
    alu_out = 4'b1100;
    instr_valid = 1'b1;
    instr = {2'b11, 2'b01, 4'b1111};
    step();
    instr_valid = 1'b0;
    step();
    step();
    check("rep8_rv_mid", result_valid, 1);
    rst = 1'b1;
    #1;
    check("rstmid_ready", instr_ready, 1);
    check("rstmid_busy",  busy, 0);
    check("rstmid_rv",    result_valid, 0);
    check("rstmid_s",     alu_s, 0);
    check("rstmid_addr",  alu_reg_addr, 0);
    check("rstmid_res",   result, 0);
    @(negedge clk);
    rst = 1'b0;
    rv_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (result_valid || busy) rv_cnt++;
    end
    check("rstmid_quiet", rv_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
